// File: rtl/serial_tx.sv
// serial_tx -- parallel-in, serial-out framed transmitter.
//
// Takes a DATA_W-bit word over a VALID/READY handshake. It then drives the
// word onto TXD as a frame: start bit (0), data LSB-first, an optional
// even-parity bit, and a stop bit (1). Each bit is held for CLKS_PER_BIT
// cycles of CK. This is the driving end of the flip-flop based serial
// receive/shift chain.
//
// Ports:
//   CK     in   rising-edge clock
//   RST_N  in   asynchronous active-low reset; release takes effect at the
//               next CK edge
//   DIN    in   [DATA_W-1:0] word to send; sampled only on the accept edge
//   VALID  in   DIN holds a word to send
//   READY  out  idle and able to accept (registered)
//   TXD    out  serial line, idles high (registered)
//   BUSY   out  frame in progress, always ~READY
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | line high, READY=1, waiting for VALID
//   S_START   | start bit (TXD=0) for CLKS_PER_BIT cycles
//   S_DATA    | data bits, LSB first, each CLKS_PER_BIT cycles
//   S_PARITY  | even-parity bit (only reached when PARITY_EN=1)
//   S_STOP    | stop bit (TXD=1) for CLKS_PER_BIT cycles, then S_IDLE

module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DIN,
  input  logic              VALID,
  output logic              READY,
  output logic              TXD,
  output logic              BUSY
);

  // A one-cycle bit time still needs a 1-bit divider, so the width is never 0.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Wide enough to hold DATA_W, so the count cannot wrap before the last bit.
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  logic              bit_done;
  logic [DATA_W-1:0] shreg_nxt;

  assign bit_done  = (div == DIV_LAST);
  // The next data bit is the one after the shift. Taking it from the shifted
  // value keeps DATA_W=1 legal, because no index [1] is needed.
  assign shreg_nxt = shreg >> 1;

  assign BUSY = ~READY;

  // TXD and READY are registered on the same edge as the state change. The
  // start bit therefore appears on the accept edge itself.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      TXD     <= 1'b1;
      READY   <= 1'b1;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          div     <= '0;
          bit_cnt <= '0;
          TXD     <= 1'b1;
          READY   <= 1'b1;
          if (VALID) begin
            shreg <= DIN;
            par   <= ^DIN;
            state <= S_START;
            TXD   <= 1'b0;
            READY <= 1'b0;
          end
        end

        S_START: begin
          if (bit_done) begin
            div   <= '0;
            state <= S_DATA;
            TXD   <= shreg[0];
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done) begin
            div   <= '0;
            shreg <= shreg_nxt;
            if (bit_cnt == CNT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                TXD   <= par;
              end else begin
                state <= S_STOP;
                TXD   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              TXD     <= shreg_nxt[0];
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            div   <= '0;
            state <= S_STOP;
            TXD   <= 1'b1;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        S_STOP: begin
          if (bit_done) begin
            div   <= '0;
            state <= S_IDLE;
            TXD   <= 1'b1;
            READY <= 1'b1;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          TXD     <= 1'b1;
          READY   <= 1'b1;
          div     <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- directed bench for serial_tx.
// Instance u_a: DATA_W=8, CLKS_PER_BIT=4, no parity.
// Instance u_b: DATA_W=8, CLKS_PER_BIT=1, even parity.
// Inputs are driven and outputs sampled on the falling edge of CK.

module tb_serial_tx;

  logic       CK;
  logic       rst_n_a, rst_n_b;
  logic [7:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       txd_a, txd_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_a (
    .CK(CK), .RST_N(rst_n_a), .DIN(din_a), .VALID(valid_a),
    .READY(ready_a), .TXD(txd_a), .BUSY(busy_a)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_b (
    .CK(CK), .RST_N(rst_n_b), .DIN(din_b), .VALID(valid_b),
    .READY(ready_b), .TXD(txd_b), .BUSY(busy_b)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Sends one frame on u_a, starting at a falling edge. The frame image is
  // {stop, data, start}, shifted out one bit every 4 samples. When keep_valid
  // is set, VALID stays high after the accept. When disturb is set, DIN is
  // changed to 3C and VALID is dropped in the middle of the data phase.
  task automatic frame_a(input logic [7:0] d, input bit keep_valid, input bit disturb);
    logic [9:0] img;
    img     = {1'b1, d, 1'b0};
    din_a   = d;
    valid_a = 1'b1;
    @(negedge CK);
    for (int k = 0; k < 40; k++) begin
      if (k == 0 && !keep_valid) valid_a = 1'b0;
      if (disturb && k == 14) begin
        din_a   = 8'h3C;
        valid_a = 1'b0;
      end
      check("a_txd", txd_a, img[0]);
      check("a_ready_low", ready_a, 1'b0);
      check("a_busy_high", busy_a, 1'b1);
      if (k % 4 == 3) img = img >> 1;
      @(negedge CK);
    end
    check("a_idle_ready", ready_a, 1'b1);
    check("a_idle_txd", txd_a, 1'b1);
    check("a_idle_busy", busy_a, 1'b0);
  endtask

  // Sends one frame on u_b (one cycle per bit) with a hand-supplied parity bit.
  task automatic frame_b(input logic [7:0] d, input logic par_exp);
    logic [10:0] img;
    img     = {1'b1, par_exp, d, 1'b0};
    din_b   = d;
    valid_b = 1'b1;
    @(negedge CK);
    valid_b = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k == 9) check("b_parity_bit", txd_b, par_exp);
      else        check("b_txd", txd_b, img[0]);
      check("b_ready_low", ready_b, 1'b0);
      img = img >> 1;
      @(negedge CK);
    end
    check("b_idle_ready", ready_b, 1'b1);
    check("b_idle_txd", txd_b, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    din_a   = 8'hA5;
    din_b   = 8'h00;
    valid_a = 1'b1;
    valid_b = 1'b1;

    // Reset held with the clock running and VALID high: no accept is allowed.
    repeat (4) begin
      @(negedge CK);
      check("rst_txd", txd_a, 1'b1);
      check("rst_ready", ready_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_b_txd", txd_b, 1'b1);
      check("rst_b_ready", ready_b, 1'b1);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge CK);
    check("post_rst_ready", ready_a, 1'b1);
    check("post_rst_txd", txd_a, 1'b1);

    // Single frame A5: bits 0,1,0,1,0,0,1,0,1,1, and READY low for 40 cycles.
    frame_a(8'hA5, 1'b0, 1'b0);

    // Back-to-back frames with VALID held high: 00, then FF after one idle cycle.
    frame_a(8'h00, 1'b1, 1'b0);
    frame_a(8'hFF, 1'b1, 1'b0);
    valid_a = 1'b0;
    @(negedge CK);
    check("b2b_no_extra_accept", ready_a, 1'b1);

    // DIN and VALID change mid-frame; the frame in flight must still carry 81.
    frame_a(8'h81, 1'b1, 1'b1);
    @(negedge CK);
    check("disturb_no_accept", ready_a, 1'b1);

    // Parity on u_b: 07 has three ones, so the bit is 1. 03 has two, so it is 0.
    frame_b(8'h07, 1'b1);
    frame_b(8'h03, 1'b0);

    // Reset mid-frame on u_a, between edges, during data bit 3 of A5 (a 0).
    din_a   = 8'hA5;
    valid_a = 1'b1;
    @(negedge CK);
    valid_a = 1'b0;
    repeat (17) @(negedge CK);
    check("mid_before_txd", txd_a, 1'b0);
    check("mid_before_ready", ready_a, 1'b0);
    #2;
    rst_n_a = 1'b0;
    #1;
    check("mid_rst_txd", txd_a, 1'b1);
    check("mid_rst_ready", ready_a, 1'b1);
    check("mid_rst_busy", busy_a, 1'b0);
    @(negedge CK);
    @(negedge CK);
    check("mid_hold_txd", txd_a, 1'b1);
    rst_n_a = 1'b1;
    // A fresh frame must begin with its start bit.
    frame_a(8'h5A, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
